fetch_sequencer: RTL



---
 rtl/fetch_seq_pkg.sv | 30 +++
 rtl/fetch_sequencer_ret_stack.sv | 64 ++++++
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// ============================================================================
//  Module   : fetch_seq_pkg
//  Brief    : Shared types and constants for the fetch sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_seq_pkg;

    localparam int c_addr_w_default = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        NPC_HOLD = 3'd0,
        NPC_INC  = 3'd1,
        NPC_BR   = 3'd2,
        NPC_JMP  = 3'd3,
        NPC_CALL = 3'd4,
        NPC_RET  = 3'd5
    } npc_sel_e;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_ret_stack.sv
// ============================================================================
//  Module   : ret_stack
//  Brief    : Return-address LIFO; push and pop are never requested together.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ret_stack
    import fetch_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = c_addr_w_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] top
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_idx_w + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;
    logic [c_idx_w-1:0] top_idx;

    assign full    = (count_q == c_cnt_w'(DEPTH));
    assign empty   = (count_q == '0);
    // Wraps to the last slot when empty; top is only consumed when non-empty.
    assign top_idx = count_q[c_idx_w-1:0] - c_idx_w'(1);
    assign top     = mem_q[top_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[count_q[c_idx_w-1:0]] = push_data;
            count_d                     = count_q + c_cnt_w'(1);
        end else if (pop && !empty) begin
            count_d = count_q - c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : PC owner and fetch FSM with prioritised next-PC selection.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W      = c_addr_w_default,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [7:0]        branch_offset,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              stack_err
);

    state_e            state_q;
    state_e            state_d;
    npc_sel_e          npc_sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_br;
    logic              instr_valid_q;
    logic              instr_valid_d;
    logic              stack_err_q;
    logic              stack_err_d;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    always_comb begin
        state_d = state_q;
        npc_sel = NPC_HOLD;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_EXEC;
            ST_EXEC: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    state_d = ST_FETCH;
                    if (ret)               npc_sel = NPC_RET;
                    else if (call)         npc_sel = NPC_CALL;
                    else if (jump)         npc_sel = NPC_JMP;
                    else if (branch_taken) npc_sel = NPC_BR;
                    else                   npc_sel = NPC_INC;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign pc_inc = pc_q + ADDR_W'(1);
    assign pc_br  = pc_q + ADDR_W'($signed(branch_offset));

    always_comb begin
        pc_d        = pc_q;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stack_err_d = stack_err_q;
        case (npc_sel)
            NPC_INC: pc_d = pc_inc;
            NPC_BR:  pc_d = pc_br;
            NPC_JMP: pc_d = jump_target;
            NPC_CALL: begin
                // An overflowing call still jumps; only the return address is lost.
                pc_d = jump_target;
                if (stk_full) stack_err_d = 1'b1;
                else          stk_push    = 1'b1;
            end
            NPC_RET: begin
                if (stk_empty) begin
                    pc_d        = pc_inc;
                    stack_err_d = 1'b1;
                end else begin
                    pc_d    = stk_top;
                    stk_pop = 1'b1;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    assign instr_valid_d = (state_q == ST_FETCH) && imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_ADDR;
            instr_valid_q <= 1'b0;
            stack_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            stack_err_q   <= stack_err_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == ST_FETCH);
    assign halted      = (state_q == ST_HALT);
    assign instr_valid = instr_valid_q;
    assign stack_err   = stack_err_q;

endmodule

`default_nettype wire
